yildiz_mem_io: RTL and testbench
================================

Name: yildiz_mem_io

Overview:
- Memory and I/O subsystem sitting directly downstream of the 16-bit CPU's memory port; it consumes the CPU's address, write data and write strobe, and returns read data.
- Holds a word-addressed RAM at 0x000–0xFEF and a memory-mapped I/O page at 0xFF0–0xFFF.
- The I/O page has an input byte FIFO with a valid/ready producer interface, a single-entry output register with a valid/ready consumer interface, and an interrupt request.

Parameters:
- ADDR_W, 12, CPU word-address width.
- DATA_W, 16, data word width.
- IO_BASE, 12'hFF0, first address of the I/O page; RAM occupies 0 .. IO_BASE-1.
- IN_DEPTH, 4, input FIFO depth in bytes; must be a power of two, 2..8.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_address  in  ADDR_W  word address from CPU.
- cpu_wdata  in  DATA_W  write data from CPU.
- cpu_write  in  1  write strobe, sampled on clk rising edge.
- cpu_rdata  out  DATA_W  read data to CPU, combinational from cpu_address.
- in_data  in  8  input byte from external producer.
- in_valid  in  1  producer has a byte.
- in_ready  out  1  FIFO not full.
- out_data  out  8  current OUTPR byte.
- out_valid  out  1  OUTPR holds an unconsumed byte.
- out_ready  in  1  consumer accepts the byte.
- irq  out  1  interrupt request, registered.
- test_inpr  out  8  FIFO head byte, 0 when empty.
- test_outpr  out  8  OUTPR register.

Behaviour:
Reset (rst=0, asynchronous):
- FIFO empty, count=0.
- OUTPR=0, out_valid=0, overrun=0, CTRL=0, irq=0.
- RAM contents are not reset.
- Reset asserted mid-transfer discards FIFO contents and any pending output byte.

RAM:
- Address < IO_BASE: cpu_rdata = mem[cpu_address] combinationally (zero-latency read).
- Write mem[cpu_address] = cpu_wdata on the rising edge when cpu_write=1.
- Read-during-write on the same address returns the old word in that cycle and the new word in the next cycle.
- Writes to the I/O page never modify RAM.

I/O map (offsets from IO_BASE); read returns 16 bits, upper unused bits are 0:
- +0 INPR:
  - Read: FIFO head byte in [7:0]; 0 when empty.
  - Write: ignored.
- +1 IN_STAT:
  - Read: bit0 FGI (count≠0), bit1 FULL, bits[7:4] count.
  - Write (any data): pops one byte if not empty; no effect if empty.
- +2 OUTPR:
  - Read: {8'h00, OUTPR}.
  - Write when out_valid=0: OUTPR = cpu_wdata[7:0] and out_valid=1 on the next edge.
  - Write when out_valid=1: data dropped and overrun set.
- +3 OUT_STAT:
  - Read: bit0 FGO (~out_valid), bit1 overrun.
  - Write (any data): clears overrun.
- +4 CTRL:
  - Read/write bits[1:0]: bit0 IEN_IN, bit1 IEN_OUT. Other bits read 0.
- +5..+15: read 0, writes ignored.

Input FIFO:
- Push when in_valid & in_ready; in_ready = (count≠IN_DEPTH), combinational from registered count.
- Push and pop in the same cycle on a non-empty FIFO: both occur, count unchanged, head advances.
- Push into an empty FIFO while a pop is written: the pop is ignored and the byte is stored.
- Read and write pointers wrap modulo IN_DEPTH.

Output:
- Handshake out_valid & out_ready clears out_valid on the next edge.
- A CPU write to OUTPR in the same cycle as a completing handshake sees out_valid=1: it is dropped and overrun is set.
- OUTPR keeps its value after it is consumed.

irq:
- Registered: irq <= (IEN_IN & count≠0) | (IEN_OUT & ~out_valid).
- One-cycle latency after the condition changes.

Test Plan:
- RAM write/read: write 0x1234 to 0x010, 0xBEEF to 0xFEF, then read both → 0x1234 and 0xBEEF. Write 0x5555 to 0xFF4 → RAM[0xFEF] still 0xBEEF and CTRL reads 0x0001.
- FIFO fill: push 0x11,0x22,0x33,0x44 → IN_STAT=0x0043, in_ready=0; a fifth in_valid with 0x55 is not accepted. Four pops return 0x11..0x44 in order, after which IN_STAT=0x0000 and INPR reads 0.
- Simultaneous push and pop at count=2 → count stays 2 and the head advances. Pop write on an empty FIFO with a concurrent push of 0x7A → count=1, INPR=0x007A.
- Output path: write 0x01C3 to OUTPR → out_data=0xC3, out_valid=1, FGO=0. Second write of 0x0099 while out_ready=0 → OUTPR stays 0xC3, OUT_STAT=0x0002. After out_ready pulse → out_valid=0; writing OUT_STAT → 0x0001.
- irq: CTRL=0x0003 with FIFO empty and out_valid=0 → irq=1 one cycle later. CTRL=0x0001 with FIFO empty → irq=0; push 0x5A → irq=1 one cycle after the push edge.
- Reset mid-operation: 3 bytes in FIFO, out_valid=1, overrun=1, CTRL=3; drop rst asynchronously between edges → immediately in_ready=1, out_valid=0, irq=0, IN_STAT=0, OUT_STAT=0x0001, test_outpr=0.

Source files
------------

// File: rtl/yildiz_mem_io.sv
// Memory and I/O subsystem for the 16-bit CPU: word RAM below IO_BASE and a
// 16-word I/O page holding an input byte FIFO, an output byte register and irq.
module yildiz_mem_io #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] IO_BASE  = 12'hFF0,
  parameter int unsigned       IN_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq,
  output logic [7:0]        test_inpr,
  output logic [7:0]        test_outpr
);

  localparam int unsigned RAM_WORDS = 32'(IO_BASE);
  localparam int unsigned PTR_W     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;

  logic [DATA_W-1:0] mem_q  [RAM_WORDS];
  logic [7:0]        fifo_q [IN_DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       outpr_q, outpr_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             irq_q, irq_d;

  logic              is_io_c;
  logic [ADDR_W-1:0] io_off_c;
  logic              ram_we_c, push_c, pop_c;
  logic              fgi_c, full_c;
  logic [7:0]        head_c;
  logic [DATA_W-1:0] rdata_c;

  // Address decode and FIFO status
  assign is_io_c  = (cpu_address >= IO_BASE);
  assign io_off_c = cpu_address - IO_BASE;
  assign ram_we_c = cpu_write & ~is_io_c;
  assign fgi_c    = (count_q != '0);
  assign full_c   = (count_q == CNT_W'(IN_DEPTH));
  assign head_c   = fgi_c ? fifo_q[rd_ptr_q] : 8'h00;
  assign push_c   = in_valid & ~full_c;
  assign pop_c    = cpu_write & is_io_c & (io_off_c == ADDR_W'(1)) & fgi_c;

  // Zero-latency read mux
  always_comb begin
    rdata_c = '0;
    if (!is_io_c) begin
      rdata_c = mem_q[cpu_address];
    end else begin
      case (io_off_c)
        ADDR_W'(0): rdata_c = DATA_W'(head_c);
        ADDR_W'(1): rdata_c = DATA_W'({4'(count_q), 2'b00, full_c, fgi_c});
        ADDR_W'(2): rdata_c = DATA_W'(outpr_q);
        ADDR_W'(3): rdata_c = DATA_W'({overrun_q, ~out_valid_q});
        ADDR_W'(4): rdata_c = DATA_W'(ctrl_q);
        default:    rdata_c = '0;
      endcase
    end
  end

  // Next-state for FIFO pointers, output register, control and irq
  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    outpr_d     = outpr_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    ctrl_d      = ctrl_q;
    irq_d       = (ctrl_q[0] & fgi_c) | (ctrl_q[1] & ~out_valid_q);

    if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop_c)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    count_d = CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(pop_c));

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (cpu_write && is_io_c) begin
      case (io_off_c)
        ADDR_W'(2): begin
          // A write racing the consuming handshake still sees the byte as pending
          if (out_valid_q) begin
            overrun_d = 1'b1;
          end else begin
            outpr_d     = cpu_wdata[7:0];
            out_valid_d = 1'b1;
          end
        end
        ADDR_W'(3): overrun_d = 1'b0;
        ADDR_W'(4): ctrl_d    = cpu_wdata[1:0];
        default: ;
      endcase
    end
  end

  // Storage arrays are not reset
  always_ff @(posedge clk) begin
    if (ram_we_c) mem_q[cpu_address] <= cpu_wdata;
    if (push_c)   fifo_q[wr_ptr_q]   <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      outpr_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      ctrl_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      outpr_q     <= outpr_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      ctrl_q      <= ctrl_d;
      irq_q       <= irq_d;
    end
  end

  assign cpu_rdata  = rdata_c;
  assign in_ready   = ~full_c;
  assign out_data   = outpr_q;
  assign out_valid  = out_valid_q;
  assign irq        = irq_q;
  assign test_inpr  = head_c;
  assign test_outpr = outpr_q;

endmodule

// File: tb/tb_yildiz_mem_io.sv
// Bench for yildiz_mem_io: directed vector table, corner sequences, and a
// randomized run checked against a queue-based model of the memory map.
module tb_yildiz_mem_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_write;
  logic [15:0] cpu_rdata;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;
  logic [7:0]  test_inpr;
  logic [7:0]  test_outpr;

  yildiz_mem_io dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .irq(irq), .test_inpr(test_inpr), .test_outpr(test_outpr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        push;
    logic [7:0]  pdata;
    logic [11:0] raddr;
    logic [15:0] exp;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [7:0]  q_m[$];
  logic [7:0]  op_m;
  logic        ov_m, orun_m, irq_m;
  logic [1:0]  ctrl_m;
  logic [15:0] ram_m[logic [11:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [15:0] d);
    cpu_address = a;
    cpu_wdata   = d;
    cpu_write   = 1'b1;
    tick();
    cpu_write   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [15:0] exp);
    cpu_address = a;
    #1;
    chk(name, 32'(cpu_rdata), 32'(exp));
  endtask

  task automatic add(input logic wr, input logic [11:0] a, input logic [15:0] d,
                     input logic push, input logic [7:0] pd,
                     input logic [11:0] ra, input logic [15:0] exp, input logic rdy);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.push = push; v.pdata = pd;
    v.raddr = ra; v.exp = exp; v.exp_rdy = rdy;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] m_read(input logic [11:0] a);
    int sz;
    sz = q_m.size();
    case (a)
      12'hFF0: return (sz != 0) ? {8'h00, q_m[0]} : 16'h0000;
      12'hFF1: return 16'((sz << 4) | ((sz == 4) ? 2 : 0) | ((sz != 0) ? 1 : 0));
      12'hFF2: return {8'h00, op_m};
      12'hFF3: return {14'd0, orun_m, ~ov_m};
      12'hFF4: return {14'd0, ctrl_m};
      default: return (a < 12'hFF0) ? ram_m[a] : 16'h0000;
    endcase
  endfunction

  initial begin
    rst = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_write = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_test_inpr", 32'(test_inpr), 0);
    chk("rst_test_outpr", 32'(test_outpr), 0);
    rd_chk("rst_in_stat", 12'hFF1, 16'h0000);
    rd_chk("rst_out_stat", 12'hFF3, 16'h0001);

    // wr, addr, wdata, push, pdata, raddr, expected rdata, expected in_ready
    add(1, 12'h010, 16'h1234, 0, 8'h00, 12'h010, 16'h1234, 1);
    add(1, 12'hFEF, 16'hBEEF, 0, 8'h00, 12'hFEF, 16'hBEEF, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'h010, 16'h1234, 1);
    add(1, 12'hFF4, 16'h5555, 0, 8'h00, 12'hFEF, 16'hBEEF, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF4, 16'h0001, 1);
    add(1, 12'hFF4, 16'h0000, 0, 8'h00, 12'hFF4, 16'h0000, 1);
    add(0, 12'h000, 16'h0000, 1, 8'h11, 12'hFF1, 16'h0011, 1);
    add(0, 12'h000, 16'h0000, 1, 8'h22, 12'hFF1, 16'h0021, 1);
    add(0, 12'h000, 16'h0000, 1, 8'h33, 12'hFF1, 16'h0031, 1);
    add(0, 12'h000, 16'h0000, 1, 8'h44, 12'hFF1, 16'h0043, 0);
    add(0, 12'h000, 16'h0000, 1, 8'h55, 12'hFF1, 16'h0043, 0);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF0, 16'h0011, 0);
    add(1, 12'hFF1, 16'h0000, 0, 8'h00, 12'hFF0, 16'h0022, 1);
    add(1, 12'hFF1, 16'hFFFF, 0, 8'h00, 12'hFF0, 16'h0033, 1);
    add(1, 12'hFF1, 16'h0000, 0, 8'h00, 12'hFF0, 16'h0044, 1);
    add(1, 12'hFF1, 16'h0000, 0, 8'h00, 12'hFF1, 16'h0000, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF0, 16'h0000, 1);
    add(1, 12'hFF1, 16'h0000, 1, 8'h7A, 12'hFF1, 16'h0011, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF0, 16'h007A, 1);
    add(0, 12'h000, 16'h0000, 1, 8'h3C, 12'hFF1, 16'h0021, 1);
    add(1, 12'hFF1, 16'h0000, 1, 8'h4D, 12'hFF1, 16'h0021, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF0, 16'h003C, 1);
    add(1, 12'hFF2, 16'h01C3, 0, 8'h00, 12'hFF2, 16'h00C3, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF3, 16'h0000, 1);
    add(1, 12'hFF2, 16'h0099, 0, 8'h00, 12'hFF2, 16'h00C3, 1);
    add(0, 12'h000, 16'h0000, 0, 8'h00, 12'hFF3, 16'h0002, 1);
    add(1, 12'hFF5, 16'hFFFF, 0, 8'h00, 12'hFF5, 16'h0000, 1);
    add(1, 12'hFF0, 16'h1234, 0, 8'h00, 12'hFF0, 16'h003C, 1);

    foreach (tbl[i]) begin
      cpu_address = tbl[i].addr;
      cpu_wdata   = tbl[i].wdata;
      cpu_write   = tbl[i].wr;
      in_valid    = tbl[i].push;
      in_data     = tbl[i].pdata;
      tick();
      cpu_write = 1'b0;
      in_valid  = 1'b0;
      rd_chk($sformatf("vec%0d_rdata", i), tbl[i].raddr, tbl[i].exp);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
    end

    // Output handshake, overrun clear
    chk("out_data_c3", 32'(out_data), 32'h0C3);
    chk("out_valid_set", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_consumed", 32'(out_valid), 0);
    chk("outpr_kept", 32'(test_outpr), 32'h0C3);
    rd_chk("out_stat_after_hs", 12'hFF3, 16'h0003);
    cpu_wr(12'hFF3, 16'h0000);
    rd_chk("out_stat_cleared", 12'hFF3, 16'h0001);

    // Write racing a completing handshake is dropped
    cpu_wr(12'hFF2, 16'h0011);
    chk("outpr_11", 32'(test_outpr), 32'h11);
    out_ready = 1'b1;
    cpu_wr(12'hFF2, 16'h0022);
    out_ready = 1'b0;
    chk("race_valid", 32'(out_valid), 0);
    chk("race_outpr", 32'(test_outpr), 32'h11);
    rd_chk("race_out_stat", 12'hFF3, 16'h0003);
    cpu_wr(12'hFF3, 16'h0000);

    // irq latency
    cpu_wr(12'hFF1, 16'h0000);
    cpu_wr(12'hFF1, 16'h0000);
    rd_chk("drained", 12'hFF1, 16'h0000);
    cpu_wr(12'hFF4, 16'h0003);
    chk("irq_lat0", 32'(irq), 0);
    tick();
    chk("irq_out_en", 32'(irq), 1);
    cpu_wr(12'hFF4, 16'h0001);
    chk("irq_hold", 32'(irq), 1);
    tick();
    chk("irq_in_only_empty", 32'(irq), 0);
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("irq_push_edge", 32'(irq), 0);
    tick();
    chk("irq_push_next", 32'(irq), 1);

    // Asynchronous reset mid-operation
    in_valid = 1'b1; in_data = 8'h61;
    tick();
    in_data = 8'h62;
    tick();
    in_valid = 1'b0;
    cpu_wr(12'hFF2, 16'h0077);
    cpu_wr(12'hFF2, 16'h0078);
    cpu_wr(12'hFF4, 16'h0003);
    rd_chk("pre_rst_in_stat", 12'hFF1, 16'h0031);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_test_outpr", 32'(test_outpr), 0);
    rd_chk("arst_in_stat", 12'hFF1, 16'h0000);
    rd_chk("arst_out_stat", 12'hFF3, 16'h0001);
    rd_chk("arst_ctrl", 12'hFF4, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    rd_chk("ram_survives_rst", 12'h010, 16'h1234);

    // RAM read-during-write
    cpu_wr(12'h020, 16'hAAAA);
    cpu_address = 12'h020; cpu_wdata = 16'hBBBB; cpu_write = 1'b1;
    #1 chk("rdw_old", 32'(cpu_rdata), 32'hAAAA);
    tick();
    cpu_write = 1'b0;
    #1 chk("rdw_new", 32'(cpu_rdata), 32'hBBBB);

    // Randomized run against the model; DUT is in its post-reset state
    q_m.delete();
    op_m = 8'h00; ov_m = 1'b0; orun_m = 1'b0; irq_m = 1'b0; ctrl_m = 2'b00;
    for (int n = 0; n < 400; n++) begin
      logic [11:0] a;
      logic        we, iv, ordy, push, pop, irq_n, nv;
      logic [15:0] wd;
      logic [7:0]  id;
      int          sz;
      case ($urandom_range(0, 2))
        0:       a = 12'(12'h000 + $urandom_range(0, 7));
        1:       a = 12'(12'hFE8 + $urandom_range(0, 7));
        default: a = 12'(12'hFF0 + $urandom_range(0, 6));
      endcase
      we = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      iv = 1'($urandom_range(0, 1));
      id = 8'($urandom);
      ordy = ($urandom_range(0, 9) < 3);
      cpu_address = a; cpu_wdata = wd; cpu_write = we;
      in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      sz = q_m.size();
      if (a >= 12'hFF0 || ram_m.exists(a))
        chk("rnd_rdata", 32'(cpu_rdata), 32'(m_read(a)));
      chk("rnd_in_ready", 32'(in_ready), (sz < 4) ? 1 : 0);
      chk("rnd_out_valid", 32'(out_valid), 32'(ov_m));
      chk("rnd_out_data", 32'(out_data), 32'(op_m));
      chk("rnd_irq", 32'(irq), 32'(irq_m));
      chk("rnd_test_inpr", 32'(test_inpr), (sz != 0) ? 32'(q_m[0]) : 0);
      @(posedge clk);
      irq_n = (ctrl_m[0] && sz != 0) || (ctrl_m[1] && !ov_m);
      push  = iv && sz < 4;
      pop   = we && a == 12'hFF1 && sz != 0;
      if (pop) void'(q_m.pop_front());
      if (push) q_m.push_back(id);
      nv = ov_m;
      if (ov_m && ordy) nv = 1'b0;
      if (we && a == 12'hFF2) begin
        if (ov_m) orun_m = 1'b1;
        else begin op_m = wd[7:0]; nv = 1'b1; end
      end
      if (we && a == 12'hFF3) orun_m = 1'b0;
      if (we && a == 12'hFF4) ctrl_m = wd[1:0];
      if (we && a < 12'hFF0) ram_m[a] = wd;
      ov_m  = nv;
      irq_m = irq_n;
      #1;
    end
    cpu_write = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
